// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and widths for the boot program loader
package prog_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;
    localparam int LEN_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } load_state_e;

    // Largest word count that fits between the base address and the top of memory.
    function automatic logic [LEN_W:0] max_words(input int addr_w, input int base_addr);
        return (LEN_W + 1)'((1 << addr_w) - base_addr);
    endfunction

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// rtl/prog_loader_byte_to_word.sv - assembles four little-endian bytes into one instruction word
module byte_to_word
    import prog_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [BYTE_W-1:0]  byte_i,
    output logic               last_byte_o,
    output logic               word_valid_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [1:0]           idx_q,   idx_d;
    logic [23:0]          asm_q,   asm_d;
    logic [INSTR_W-1:0]   word_q,  word_d;
    logic                 valid_q, valid_d;

    // The byte currently offered completes a word when three lanes are already filled.
    assign last_byte_o  = (idx_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

    // Next-state: place each byte in its lane; on the fourth, publish the word for one cycle.
    always_comb begin
        idx_d   = idx_q;
        asm_d   = asm_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear_i) begin
            idx_d = 2'd0;
            asm_d = '0;
        end else if (byte_valid_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    asm_d[7:0]   = byte_i;
                2'd1:    asm_d[15:8]  = byte_i;
                2'd2:    asm_d[23:16] = byte_i;
                default: begin
                    word_d  = {byte_i, asm_q};
                    valid_d = 1'b1;
                end
            endcase
        end
    end

    // Assembly registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            asm_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: byte stream to instruction memory, holds CPU in reset until verified
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    input  logic [BYTE_W-1:0]  in_byte_i,
    output logic               in_ready_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    output logic               cpu_rst_out_o,
    output logic               done_o,
    output logic               error_o
);

    localparam logic [LEN_W:0]    MAX_WORDS = max_words(ADDR_W, BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    load_state_e          state_q, state_d;
    logic [BYTE_W-1:0]    len_lo_q, len_lo_d;
    logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
    logic [BYTE_W-1:0]    csum_q, csum_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 cpu_rst_q, cpu_rst_d;

    logic                 xfer;
    logic                 start_act;
    logic [LEN_W-1:0]     len_full;
    logic                 data_byte;
    logic                 last_byte;
    logic                 word_valid;
    logic [INSTR_W-1:0]   word;

    assign xfer      = in_valid_i & in_ready_o;
    assign start_act = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
    assign len_full  = {in_byte_i, len_lo_q};
    assign data_byte = xfer & (state_q == ST_DATA);

    byte_to_word u_b2w (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (start_act),
        .byte_valid_i (data_byte),
        .byte_i       (in_byte_i),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: walk the frame; oversized lengths abort before any data is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                if (xfer) state_d = ST_LEN1;
            end
            ST_LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_WORDS) state_d = ST_ERR;
                    else if (len_full == '0)          state_d = ST_CSUM;
                    else                              state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer && last_byte && (word_cnt_q == LEN_W'(1))) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (xfer) state_d = (in_byte_i == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        in_ready_o = 1'b0;
        done_o     = 1'b0;
        error_o    = 1'b0;
        case (state_q)
            ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: in_ready_o = 1'b1;
            ST_DONE:                            done_o     = 1'b1;
            ST_ERR:                             error_o    = 1'b1;
            default: ;
        endcase
    end

    assign mem_we_o      = word_valid;
    assign mem_wdata_o   = word;
    assign mem_addr_o    = addr_q;
    assign cpu_rst_out_o = cpu_rst_q;

    // Datapath next-state: length capture, word countdown, running XOR, write address.
    always_comb begin
        len_lo_d   = len_lo_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        // CPU leaves reset only while sitting in DONE with no new load requested.
        cpu_rst_d  = !((state_q == ST_DONE) && !start_i);
        if (start_act) begin
            word_cnt_d = '0;
            csum_d     = '0;
            addr_d     = BASE;
        end else begin
            if (xfer && (state_q == ST_LEN0)) len_lo_d = in_byte_i;
            if (xfer && (state_q == ST_LEN1)) word_cnt_d = len_full;
            if (data_byte) begin
                csum_d = csum_q ^ in_byte_i;
                if (last_byte) word_cnt_d = word_cnt_q - LEN_W'(1);
            end
            if (word_valid) addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_lo_q   <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            addr_q     <= BASE;
            cpu_rst_q  <= 1'b1;
        end else begin
            len_lo_q   <= len_lo_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_out;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_total = 0;

    localparam logic [31:0] W0   = 32'h00500113;
    localparam logic [31:0] W1   = 32'h00B00193;
    localparam logic [7:0]  CSUM = 8'h60;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_byte_i     (in_byte),
        .in_ready_o    (in_ready),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .cpu_rst_out_o (cpu_rst_out),
        .done_o        (done),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] = mem_addr;
                wr_data[wr_total] = mem_wdata;
            end
            wr_total = wr_total + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        cnt = 0;
        while (!in_ready && cnt < 16) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic check_writes(input string name, input int base);
        total++;
        if (wr_total - base !== 2) begin
            bad++;
            $display("FAIL %s_count: writes=%0d required 2", name, wr_total - base);
        end else begin
            total++;
            if (wr_addr[base] !== 8'd0 || wr_data[base] !== W0) begin
                bad++;
                $display("FAIL %s_w0: addr=%0d data=%08h required 0 %08h", name, wr_addr[base], wr_data[base], W0);
            end
            total++;
            if (wr_addr[base+1] !== 8'd1 || wr_data[base+1] !== W1) begin
                bad++;
                $display("FAIL %s_w1: addr=%0d data=%08h required 1 %08h", name, wr_addr[base+1], wr_data[base+1], W1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({cpu_rst_out, in_ready, mem_we, done, error} !== 5'b10000 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset: rst/rdy/we/done/err=%b addr=%0d wdata=%08h required 10000 0 0",
                     {cpu_rst_out, in_ready, mem_we, done, error}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_ready: in_ready=%0b required 0", in_ready);
        end
    endtask

    task automatic test_load();
        int base = wr_total;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(W0, 0);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== W0) begin
            bad++;
            $display("FAIL load_latency: we=%0b addr=%0d data=%08h required 1 0 %08h", mem_we, mem_addr, mem_wdata, W0);
        end
        send_word(W1, 0);
        send_byte(CSUM, 0);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst_out !== 1'b1) begin
            bad++;
            $display("FAIL load_done_entry: done=%0b err=%0b cpu_rst=%0b required 1 0 1", done, error, cpu_rst_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (cpu_rst_out !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL load_cpu_release: cpu_rst=%0b done=%0b required 0 1", cpu_rst_out, done);
        end
        repeat (2) @(negedge clk);
        check_writes("load", base);
    endtask

    task automatic test_bad_csum();
        int base = wr_total;
        pulse_start();
        total++;
        if (cpu_rst_out !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL restart_clear: cpu_rst=%0b done=%0b required 1 0", cpu_rst_out, done);
        end
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(W0, 0);
        send_word(W1, 0);
        send_byte(CSUM ^ 8'hFF, 0);
        repeat (3) @(negedge clk);
        total++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_rst_out !== 1'b1) begin
            bad++;
            $display("FAIL bad_csum: err=%0b done=%0b cpu_rst=%0b required 1 0 1", error, done, cpu_rst_out);
        end
        check_writes("bad_csum", base);
    endtask

    task automatic test_gaps();
        int base = wr_total;
        pulse_start();
        send_byte(8'h02, 3);
        pulse_start();
        send_byte(8'h00, 3);
        send_word(W0, 3);
        send_word(W1, 3);
        send_byte(CSUM, 3);
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst_out !== 1'b0) begin
            bad++;
            $display("FAIL gaps_result: done=%0b err=%0b cpu_rst=%0b required 1 0 0", done, error, cpu_rst_out);
        end
        check_writes("gaps", base);
    endtask

    task automatic test_lengths();
        int base = wr_total;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || wr_total !== base) begin
            bad++;
            $display("FAIL empty_image: done=%0b err=%0b writes=%0d required 1 0 0", done, error, wr_total - base);
        end
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        total++;
        if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL overflow: err=%0b rdy=%0b done=%0b required 1 0 0", error, in_ready, done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wr_total !== base || cpu_rst_out !== 1'b1) begin
            bad++;
            $display("FAIL overflow_nowrite: writes=%0d cpu_rst=%0b required 0 1", wr_total - base, cpu_rst_out);
        end
    endtask

    task automatic test_reset_midload();
        int base;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(W0, 0);
        send_byte(W1[7:0], 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({cpu_rst_out, in_ready, mem_we, done, error} !== 5'b10000 || mem_addr !== 8'd0) begin
            bad++;
            $display("FAIL midload_reset: rst/rdy/we/done/err=%b addr=%0d required 10000 0",
                     {cpu_rst_out, in_ready, mem_we, done, error}, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        base = wr_total;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(W0, 0);
        send_word(W1, 0);
        send_byte(CSUM, 0);
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst_out !== 1'b0) begin
            bad++;
            $display("FAIL reload_result: done=%0b err=%0b cpu_rst=%0b required 1 0 0", done, error, cpu_rst_out);
        end
        check_writes("reload", base);
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_csum();
        test_gaps();
        test_lengths();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
